// File: rtl/add_if_core_if.sv
// rtl/add_if_core_if.sv - operand/sum handshake bundle for add_if_core (cin present with ADD_IF_CARRY_IN_EN)
interface add_if_core_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ADD_IF_CARRY_IN_EN
    logic             cin;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;

`ifdef ADD_IF_CARRY_IN_EN
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum
    );
`endif
endinterface

// File: rtl/add_if_core.sv
// rtl/add_if_core.sv - registered full-precision unsigned adder with one-entry output buffer (optional cin via ADD_IF_CARRY_IN_EN)
module add_if_core #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    add_if_core_if.slave bus
);
    logic           out_valid_q;
    logic [WIDTH:0] sum_q;
    logic [WIDTH:0] carry_ext;
    logic           accept;

`ifdef ADD_IF_CARRY_IN_EN
    assign carry_ext = {{WIDTH{1'b0}}, bus.cin};
`else
    assign carry_ext = '0;
`endif

    // Ready depends only on buffer state and consumer, never on in_valid.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else if (accept) begin
            // Operands only reach the register when accepted, so idle X never lands in sum.
            sum_q       <= {1'b0, bus.a} + {1'b0, bus.b} + carry_ext;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_if_core.sv
// tb/tb_add_if_core.sv - randomized self-checking bench for add_if_core against a queue-based model
module tb_add_if_core;
    localparam int WIDTH = 4;
`ifdef ADD_IF_CARRY_IN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    add_if_core_if #(.WIDTH(WIDTH)) bus ();

    add_if_core #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: results in flight as a queue of plain integer sums.
    int q[$];
    int last_sum;
    bit known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit iv, input int av, input int bv, input bit c, input bit ordy);
        bit acc;
        rst           = r;
        bus.in_valid  = iv;
        bus.a         = av[WIDTH-1:0];
        bus.b         = bv[WIDTH-1:0];
`ifdef ADD_IF_CARRY_IN_EN
        bus.cin       = c;
`endif
        bus.out_ready = ordy;
        #1;
        if (known)
            check("in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || ordy));
        @(posedge clk);
        if (r) begin
            q.delete();
            last_sum = 0;
            known    = 1'b1;
        end else begin
            acc = iv && (q.size() == 0 || ordy);
            if (q.size() != 0 && ordy)
                last_sum = q.pop_front();
            if (acc)
                q.push_back(av + bv + ((CIN_EN && c) ? 1 : 0));
        end
        @(negedge clk);
        if (known) begin
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check("sum", 32'(bus.sum), 32'((q.size() != 0) ? q[0] : last_sum));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        known    = 1'b0;
        last_sum = 0;
        rst      = 1'b1;

        // Reset held two cycles, then idle.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Basic sequence with consumer always ready.
        step(0, 1, 4, 3, 0, 1);
        step(0, 1, 5, 3, 0, 1);
        step(0, 1, 5, 2, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Maximum operands, without and with carry-in.
        step(0, 1, 15, 15, 0, 1);
        step(0, 1, 15, 15, 1, 1);
        step(0, 0, 0, 0, 0, 1);

        // Back-pressure: 2+1 held for three cycles while new operands are offered.
        step(0, 1, 2, 1, 0, 1);
        step(0, 1, 9, 9, 0, 0);
        step(0, 1, 7, 6, 1, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 6, 6, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Streaming: one result per cycle, no bubbles.
        for (int i = 0; i < 8; i++)
            step(0, 1, i, i, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Reset during a stall drops the pending result.
        step(0, 1, 12, 3, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 8, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom % 60) == 0, ($urandom % 4) != 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom % 2), ($urandom % 3) != 0);
        step(0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
